// File: rtl/seven_segment_scan_driver_if.sv
// Bundle between a numeric source and the seven-segment scan driver.
// Latency: none (wires only).
// Backpressure: none; load is a fire-and-forget strobe, pending reports an uncommitted shadow.
//
// Signals (master = value source / display consumer, slave = scan driver):
//   load      strobe: capture number/dots into the driver's shadow
//   number    4*w_digit hex value, nibble k feeds digit k
//   dots      per-digit decimal point
//   pending   shadow not yet committed to the display
//   abcdefgh  active-high segments, bit7 = a ... bit1 = g, bit0 = dot
//   digit     active-high one-hot digit select
interface seven_segment_scan_driver_if #(
    parameter int w_digit = 8
);
    logic                   load;
    logic [4*w_digit-1:0]   number;
    logic [w_digit-1:0]     dots;
    logic                   pending;
    logic [7:0]             abcdefgh;
    logic [w_digit-1:0]     digit;

    modport master (
        output load,
        output number,
        output dots,
        input  pending,
        input  abcdefgh,
        input  digit
    );

    modport slave (
        input  load,
        input  number,
        input  dots,
        output pending,
        output abcdefgh,
        output digit
    );
endinterface

// File: rtl/seven_segment_scan_driver.sv
// Time-multiplexed w_digit-digit seven-segment driver with frame-aligned commit of a shadowed value.
// Latency: a load is shown from the next frame wrap; outputs update one cycle after each refresh tick.
// Backpressure: none; load is always accepted, the last load before a wrap wins.
//
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset (all outputs dark)
//   bus    seven_segment_scan_driver_if.slave (load/number/dots in, pending/abcdefgh/digit out)
// Optional feature: define SEEN_SEG macro SEVEN_SEG_LEADING_ZERO_BLANK_EN to blank leading-zero digits.
module seven_segment_scan_driver #(
    parameter int clk_mhz    = 50,
    parameter int w_digit    = 8,
    parameter int refresh_hz = 1000
) (
    input  logic                        clk,
    input  logic                        rst_n,
    seven_segment_scan_driver_if.slave  bus
);

    localparam int TICK_P = (clk_mhz * 1_000_000) / refresh_hz;
    localparam int CNT_W  = (TICK_P < 2) ? 1 : $clog2(TICK_P);
    localparam int IDX_W  = $clog2(w_digit);

    if (TICK_P < 2) begin : g_bad_period
        $error("seven_segment_scan_driver: refresh tick period must be at least 2 clocks");
    end

    if (w_digit < 2) begin : g_bad_width
        $error("seven_segment_scan_driver: w_digit must be at least 2");
    end

    logic [CNT_W-1:0]       r_cnt;
    logic [IDX_W-1:0]       r_idx;
    logic [4*w_digit-1:0]   r_shadow_num;
    logic [w_digit-1:0]     r_shadow_dots;
    logic [4*w_digit-1:0]   r_disp_num;
    logic [w_digit-1:0]     r_disp_dots;
    logic                   r_pending;
    logic [7:0]             r_seg;
    logic [w_digit-1:0]     r_dig;

    logic                   w_tick;
    logic                   w_wrap;
    logic [IDX_W-1:0]       w_idx_nxt;
    logic [4*w_digit-1:0]   w_src_num;
    logic [w_digit-1:0]     w_src_dots;
    logic [3:0]             w_nib;
    logic [6:0]             w_seg7;
    logic                   w_blank;
    logic [7:0]             w_seg_nxt;
    logic [w_digit-1:0]     w_dig_nxt;

    assign w_tick    = (r_cnt == CNT_W'(TICK_P - 1));
    assign w_idx_nxt = (r_idx == IDX_W'(w_digit - 1)) ? '0 : r_idx + 1'b1;
    assign w_wrap    = w_tick && (w_idx_nxt == '0);

    // On the wrap tick the display register is being loaded in the same edge,
    // so digit 0 must decode straight from the shadow it is about to take.
    assign w_src_num  = w_wrap ? r_shadow_num  : r_disp_num;
    assign w_src_dots = w_wrap ? r_shadow_dots : r_disp_dots;

    assign w_nib = w_src_num[{w_idx_nxt, 2'b00} +: 4];

    always_comb begin
        w_seg7 = 7'b0000000;
        case (w_nib)
            4'h0: w_seg7 = 7'b1111110;
            4'h1: w_seg7 = 7'b0110000;
            4'h2: w_seg7 = 7'b1101101;
            4'h3: w_seg7 = 7'b1111001;
            4'h4: w_seg7 = 7'b0110011;
            4'h5: w_seg7 = 7'b1011011;
            4'h6: w_seg7 = 7'b1011111;
            4'h7: w_seg7 = 7'b1110000;
            4'h8: w_seg7 = 7'b1111111;
            4'h9: w_seg7 = 7'b1111011;
            4'hA: w_seg7 = 7'b1110111;
            4'hB: w_seg7 = 7'b0011111;
            4'hC: w_seg7 = 7'b1001110;
            4'hD: w_seg7 = 7'b0111101;
            4'hE: w_seg7 = 7'b1001111;
            4'hF: w_seg7 = 7'b1000111;
            default: w_seg7 = 7'b0000000;
        endcase
    end

`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
    // Shifting the digit down to bit 0 leaves exactly nibbles k..w_digit-1;
    // if those are all zero this digit is a leading zero. Digit 0 always shows.
    assign w_blank = (w_idx_nxt != '0) && ((w_src_num >> {w_idx_nxt, 2'b00}) == '0);
`else
    assign w_blank = 1'b0;
`endif

    assign w_seg_nxt = {(w_blank ? 7'b0000000 : w_seg7), w_src_dots[w_idx_nxt]};

    always_comb begin
        w_dig_nxt            = '0;
        w_dig_nxt[w_idx_nxt] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt         <= '0;
            r_idx         <= '0;
            r_shadow_num  <= '0;
            r_shadow_dots <= '0;
            r_disp_num    <= '0;
            r_disp_dots   <= '0;
            r_pending     <= 1'b0;
            r_seg         <= 8'h00;
            r_dig         <= '0;
        end else begin
            r_cnt <= w_tick ? '0 : r_cnt + 1'b1;

            // Segments and select move on the same edge so no mixed frame is ever driven.
            if (w_tick) begin
                r_idx <= w_idx_nxt;
                r_seg <= w_seg_nxt;
                r_dig <= w_dig_nxt;
            end

            // Commit uses the pre-load shadow even if a load lands on the wrap edge.
            if (w_wrap) begin
                r_disp_num  <= r_shadow_num;
                r_disp_dots <= r_shadow_dots;
            end

            if (bus.load) begin
                r_shadow_num  <= bus.number;
                r_shadow_dots <= bus.dots;
            end

            // A load on the wrap edge is still uncommitted, so it keeps pending set.
            if (bus.load) begin
                r_pending <= 1'b1;
            end else if (w_wrap) begin
                r_pending <= 1'b0;
            end
        end
    end

    assign bus.pending  = r_pending;
    assign bus.abcdefgh = r_seg;
    assign bus.digit    = r_dig;

endmodule
